// File: rtl/jk_counter_ctrl.sv
// rtl/jk_counter_ctrl.sv - JK flip-flop bank sequencer for a mod-N up/down counter
// Optional: JK_CTRL_PRESET_EN adds async active-low pre_bar (q -> MODULUS-1, state -> HALT)

module jk_counter_ctrl #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             clr_bar,
`ifdef JK_CTRL_PRESET_EN
  input  logic             pre_bar,
`endif
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             busy,
  output logic             tc,
  output logic [7:0]       wrap_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  // Modulus compared one bit wider so MODULUS == 2**WIDTH stays representable
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] load_tgt;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] up_mask;
  logic [WIDTH-1:0] dn_mask;
  logic [7:0]       wc_next;
  logic             wrap;
  logic             clr_wc;
  logic             cap_load;
  logic             run_go;
  logic             out_of_range;
  logic             at_top;
  logic             at_zero;

  // Stage i toggles when every lower stage of v is 1 (stage 0 always toggles)
  function automatic logic [WIDTH-1:0] toggle_mask(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    logic             acc;
    acc = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = acc;
      acc  = acc & v[i];
    end
    return m;
  endfunction

  assign up_mask      = toggle_mask(q);
  assign dn_mask      = toggle_mask(~q);
  assign out_of_range = ({1'b0, q} >= MOD_EXT);
  assign at_top       = (q == TOP);
  assign at_zero      = (q == '0);
  assign run_go       = start & ~stop;
  assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? TOP : load_val;
  assign busy         = (state == ST_RUN);

  // Next state, J/K drive and wrap detection; stop beats start, load beats both
  always_comb begin
    state_next = state;
    j_vec      = '0;
    k_vec      = '0;
    wrap       = 1'b0;
    clr_wc     = 1'b0;
    cap_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          state_next = ST_LOAD;
          cap_load   = 1'b1;
        end else if (run_go) begin
          state_next = ST_RUN;
        end
      end
      ST_LOAD: begin
        j_vec      = load_tgt & ~q;
        k_vec      = ~load_tgt & q;
        clr_wc     = 1'b1;
        state_next = run_go ? ST_RUN : ST_HALT;
      end
      ST_RUN: begin
        // A load or stop request holds q at this edge; counting happens otherwise
        if (load) begin
          state_next = ST_LOAD;
          cap_load   = 1'b1;
        end else if (stop) begin
          state_next = ST_HALT;
        end else if (out_of_range) begin
          k_vec = q;
        end else if (up_dn) begin
          if (at_top) begin
            k_vec = q;
            wrap  = 1'b1;
          end else begin
            j_vec = up_mask;
            k_vec = up_mask;
          end
        end else begin
          if (at_zero) begin
            j_vec = TOP & ~q;
            k_vec = ~TOP & q;
            wrap  = 1'b1;
          end else begin
            j_vec = dn_mask;
            k_vec = dn_mask;
          end
        end
      end
      ST_HALT: begin
        if (load) begin
          state_next = ST_LOAD;
          cap_load   = 1'b1;
        end else if (run_go) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // JK characteristic equation applied bitwise to the register bank
  always_comb begin
    q_next = (j_vec & ~q) | (~k_vec & q);
  end

  // Wrap counter: cleared by the load edge, saturates at 255
  always_comb begin
    wc_next = wrap_cnt;
    if (clr_wc) begin
      wc_next = 8'd0;
    end else if (wrap && (wrap_cnt != 8'hFF)) begin
      wc_next = wrap_cnt + 8'd1;
    end
  end

`ifdef JK_CTRL_PRESET_EN
  // Core registers: clear wins over preset; preset parks the counter at its top value in HALT
  always_ff @(posedge clk or negedge clr_bar or negedge pre_bar) begin
    if (!clr_bar) begin
      q     <= '0;
      state <= ST_IDLE;
      tc    <= 1'b0;
    end else if (!pre_bar) begin
      q     <= TOP;
      state <= ST_HALT;
      tc    <= 1'b0;
    end else begin
      q     <= q_next;
      state <= state_next;
      tc    <= wrap;
    end
  end
`else
  // Core registers: JK bank, FSM state and the one-cycle wrap pulse
  always_ff @(posedge clk or negedge clr_bar) begin
    if (!clr_bar) begin
      q     <= '0;
      state <= ST_IDLE;
      tc    <= 1'b0;
    end else begin
      q     <= q_next;
      state <= state_next;
      tc    <= wrap;
    end
  end
`endif

  // Wrap count and load target are untouched by preset, so they live outside the core block
  always_ff @(posedge clk or negedge clr_bar) begin
    if (!clr_bar) begin
      wrap_cnt <= 8'd0;
      load_tgt <= '0;
    end else begin
      wrap_cnt <= wc_next;
      if (cap_load) begin
        load_tgt <= load_clamped;
      end
    end
  end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// tb/tb_jk_counter_ctrl.sv - self-checking bench for jk_counter_ctrl (WIDTH=4, MODULUS=10)

module tb_jk_counter_ctrl;

  localparam int W = 4;
  localparam int M = 10;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_RUN  = 2;
  localparam int S_HALT = 3;

  logic         clk = 1'b0;
  logic         clr_bar;
  logic         start;
  logic         stop;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic [W-1:0] j_vec;
  logic [W-1:0] k_vec;
  logic         busy;
  logic         tc;
  logic [7:0]   wrap_cnt;
`ifdef JK_CTRL_PRESET_EN
  logic         pre_bar;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int m_state, m_q, m_tc, m_wc, m_tgt;
  int n_state, n_q, n_tc, n_wc, n_tgt;
  int ej, ek;

  typedef struct {
    logic       s;
    logic       p;
    logic       u;
    logic       l;
    logic [3:0] lv;
    int         eq;
    logic       eb;
    logic       et;
    int         ewc;
    logic       cjk;
    int         ejv;
    int         ekv;
  } vec_t;

  vec_t tbl[$];

  jk_counter_ctrl #(.WIDTH(W), .MODULUS(M)) dut (
    .clk      (clk),
    .clr_bar  (clr_bar),
`ifdef JK_CTRL_PRESET_EN
    .pre_bar  (pre_bar),
`endif
    .start    (start),
    .stop     (stop),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .j_vec    (j_vec),
    .k_vec    (k_vec),
    .busy     (busy),
    .tc       (tc),
    .wrap_cnt (wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_row(input logic s, input logic p, input logic u, input logic l,
                         input logic [3:0] lv, input int eq, input logic eb, input logic et,
                         input int ewc, input logic cjk, input int ejv, input int ekv);
    vec_t v;
    v.s = s; v.p = p; v.u = u; v.l = l; v.lv = lv;
    v.eq = eq; v.eb = eb; v.et = et; v.ewc = ewc;
    v.cjk = cjk; v.ejv = ejv; v.ekv = ekv;
    tbl.push_back(v);
  endtask

  task automatic set_in(input logic s, input logic p, input logic u, input logic l,
                        input logic [3:0] lv);
    start = s; stop = p; up_dn = u; load = l; load_val = lv;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_q = 0; m_tc = 0; m_wc = 0; m_tgt = 0;
  endtask

  // Counter behaviour from the arithmetic rules: next count, then J/K as the drive reaching it
  task automatic model_predict();
    bit go;
    bit toggle;
    go      = start && !stop;
    toggle  = 1'b0;
    n_state = m_state; n_q = m_q; n_tc = 0; n_wc = m_wc; n_tgt = m_tgt;
    case (m_state)
      S_IDLE, S_HALT: begin
        if (load) begin
          n_state = S_LOAD;
          n_tgt   = (int'(load_val) >= M) ? M - 1 : int'(load_val);
        end else if (go) begin
          n_state = S_RUN;
        end
      end
      S_LOAD: begin
        n_q     = m_tgt;
        n_wc    = 0;
        n_state = go ? S_RUN : S_HALT;
      end
      default: begin
        if (load) begin
          n_state = S_LOAD;
          n_tgt   = (int'(load_val) >= M) ? M - 1 : int'(load_val);
        end else if (stop) begin
          n_state = S_HALT;
        end else if (m_q >= M) begin
          n_q = 0;
        end else if (up_dn) begin
          n_q = (m_q + 1) % M;
          if (m_q == M - 1) n_tc = 1; else toggle = 1'b1;
        end else begin
          n_q = (m_q + M - 1) % M;
          if (m_q == 0) n_tc = 1; else toggle = 1'b1;
        end
        if (n_tc == 1) n_wc = (m_wc < 255) ? m_wc + 1 : 255;
      end
    endcase
    if (toggle) begin
      ej = m_q ^ n_q;
      ek = m_q ^ n_q;
    end else begin
      ej = n_q & ~m_q & 15;
      ek = m_q & ~n_q & 15;
    end
  endtask

  task automatic cycle_model();
    #1;
    model_predict();
    check("j_vec", 32'(j_vec), 32'(ej));
    check("k_vec", 32'(k_vec), 32'(ek));
    @(posedge clk);
    #1;
    m_state = n_state; m_q = n_q; m_tc = n_tc; m_wc = n_wc; m_tgt = n_tgt;
    check("q", 32'(q), 32'(m_q));
    check("busy", 32'(busy), 32'(m_state == S_RUN));
    check("tc", 32'(tc), 32'(m_tc));
    check("wrap_cnt", 32'(wrap_cnt), 32'(m_wc));
  endtask

  initial begin
    clr_bar = 1'b0;
`ifdef JK_CTRL_PRESET_EN
    pre_bar = 1'b1;
`endif
    set_in(0, 0, 1, 0, 4'd0);

    // Reset values while clr_bar is held low
    #3;
    check("rst_q", 32'(q), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tc", 32'(tc), 0);
    check("rst_wrap_cnt", 32'(wrap_cnt), 0);
    check("rst_j", 32'(j_vec), 0);
    check("rst_k", 32'(k_vec), 0);
    edge1();
    clr_bar = 1'b1;

    // s p u l lv | q busy tc wc | chk j k
    add_row(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) add_row(1, 0, 1, 0, 0, i, 1, 0, 0, 0, 0, 0);
    add_row(1, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    add_row(1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    add_row(1, 0, 1, 0, 0, 2, 1, 0, 1, 0, 0, 0);
    add_row(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    add_row(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 9, 0);
    add_row(1, 0, 0, 0, 0, 9, 1, 1, 2, 0, 0, 0);
    add_row(1, 0, 0, 0, 0, 8, 1, 0, 2, 0, 0, 0);
    add_row(1, 0, 1, 1, 5, -1, 0, 0, 2, 0, 0, 0);
    add_row(1, 0, 1, 0, 5, 5, 1, 0, 0, 0, 0, 0);
    add_row(1, 0, 1, 0, 5, 6, 1, 0, 0, 0, 0, 0);
    add_row(1, 0, 1, 1, 13, -1, 0, 0, 0, 0, 0, 0);
    add_row(1, 0, 1, 0, 13, 9, 1, 0, 0, 0, 0, 0);
    add_row(1, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add_row(1, 0, 1, 0, 0, i, 1, 0, 1, 0, 0, 0);
    add_row(1, 1, 1, 0, 0, 4, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) add_row(0, 1, 1, 0, 0, 4, 0, 0, 1, 1, 0, 0);
    add_row(1, 0, 1, 0, 0, 4, 1, 0, 1, 1, 1, 1);
    add_row(1, 0, 1, 0, 0, 5, 1, 0, 1, 0, 0, 0);
    add_row(1, 1, 1, 0, 0, 5, 0, 0, 1, 1, 0, 0);
    add_row(1, 1, 1, 0, 0, 5, 0, 0, 1, 1, 0, 0);
    add_row(1, 1, 1, 0, 0, 5, 0, 0, 1, 1, 0, 0);

    foreach (tbl[r]) begin
      set_in(tbl[r].s, tbl[r].p, tbl[r].u, tbl[r].l, tbl[r].lv);
      edge1();
      if (tbl[r].eq >= 0) check($sformatf("row%0d_q", r), 32'(q), 32'(tbl[r].eq));
      check($sformatf("row%0d_busy", r), 32'(busy), 32'(tbl[r].eb));
      check($sformatf("row%0d_tc", r), 32'(tc), 32'(tbl[r].et));
      check($sformatf("row%0d_wrap_cnt", r), 32'(wrap_cnt), 32'(tbl[r].ewc));
      if (tbl[r].cjk) begin
        check($sformatf("row%0d_j", r), 32'(j_vec), 32'(tbl[r].ejv));
        check($sformatf("row%0d_k", r), 32'(k_vec), 32'(tbl[r].ekv));
      end
    end

    // Async clear mid-count at q=7
    set_in(1, 0, 1, 0, 0);
    repeat (3) edge1();
    check("pre_clr_q7", 32'(q), 7);
    #2 clr_bar = 1'b0;
    #1;
    check("clr_q", 32'(q), 0);
    check("clr_busy", 32'(busy), 0);
    check("clr_tc", 32'(tc), 0);
    check("clr_wrap_cnt", 32'(wrap_cnt), 0);
    check("clr_j", 32'(j_vec), 0);
    edge1();
    clr_bar = 1'b1;

    // Async clear while tc is high right after a wrap
    repeat (11) edge1();
    check("wrap_q", 32'(q), 0);
    check("wrap_tc", 32'(tc), 1);
    #2 clr_bar = 1'b0;
    #1;
    check("clr2_tc", 32'(tc), 0);
    check("clr2_wrap_cnt", 32'(wrap_cnt), 0);
    check("clr2_busy", 32'(busy), 0);
    edge1();
    clr_bar = 1'b1;
    set_in(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      edge1();
      check("idle_busy", 32'(busy), 0);
      check("idle_q", 32'(q), 0);
    end

    // Saturation of wrap_cnt over a long uninterrupted up-count
    model_reset();
    set_in(1, 0, 1, 0, 0);
    for (int i = 0; i < 2600; i++) cycle_model();
    check("sat_wrap_cnt", 32'(wrap_cnt), 255);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 3) != 0);
      stop     = ($urandom_range(0, 11) == 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) up_dn = ~up_dn;
      cycle_model();
    end

`ifdef JK_CTRL_PRESET_EN
    // Async preset to MODULUS-1 in HALT; clear beats preset
    clr_bar = 1'b0;
    #2 clr_bar = 1'b1;
    set_in(1, 0, 1, 0, 0);
    repeat (4) edge1();
    check("pre_q3", 32'(q), 3);
    #2 pre_bar = 1'b0;
    #1;
    check("preset_q", 32'(q), 9);
    check("preset_busy", 32'(busy), 0);
    check("preset_tc", 32'(tc), 0);
    edge1();
    pre_bar = 1'b1;
    set_in(0, 0, 1, 0, 0);
    edge1();
    check("preset_hold_q", 32'(q), 9);
    check("preset_hold_busy", 32'(busy), 0);
    #2;
    clr_bar = 1'b0;
    pre_bar = 1'b0;
    #1;
    check("clr_over_pre_q", 32'(q), 0);
    #2;
    clr_bar = 1'b1;
    pre_bar = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
